reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param_if.sv | 32 +++
 rtl/reg_file_param.sv | 76 +++++++
 tb/tb_reg_file_param.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_param_if.sv
// Register-file access bundle: two read ports with enable/valid plus one write port.
// The master drives addresses, enables and write data; the slave returns read data and valid flags.
interface reg_file_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] Read_Register1;
    logic                  Read_Enable1;
    logic [DATA_WIDTH-1:0] Read_Data1;
    logic                  Read_Valid1;

    logic [ADDR_WIDTH-1:0] Read_Register2;
    logic                  Read_Enable2;
    logic [DATA_WIDTH-1:0] Read_Data2;
    logic                  Read_Valid2;

    logic [ADDR_WIDTH-1:0] Write_Register;
    logic [DATA_WIDTH-1:0] Write_Data;
    logic                  Reg_Write;

    modport master (
        output Read_Register1, Read_Enable1, Read_Register2, Read_Enable2,
        output Write_Register, Write_Data, Reg_Write,
        input  Read_Data1, Read_Valid1, Read_Data2, Read_Valid2
    );

    modport slave (
        input  Read_Register1, Read_Enable1, Read_Register2, Read_Enable2,
        input  Write_Register, Write_Data, Reg_Write,
        output Read_Data1, Read_Valid1, Read_Data2, Read_Valid2
    );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file: one write port, two registered read ports with
// optional hardwired-zero entry 0 and optional same-cycle write-to-read forwarding.
module reg_file_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    reg_file_param_if.slave   rf
);
    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;
    logic                  rvalid1_q, rvalid1_d;
    logic                  rvalid2_q, rvalid2_d;
    logic                  wr_en;

    // Writes to entry 0 are dropped when it is hardwired, so forwarding never sees them either.
    always_comb begin
        wr_en     = rf.Reg_Write && !(ZERO_REG && (rf.Write_Register == '0));
        rdata1_d  = rdata1_q;
        rdata2_d  = rdata2_q;
        rvalid1_d = rf.Read_Enable1;
        rvalid2_d = rf.Read_Enable2;

        if (rf.Read_Enable1) begin
            if (ZERO_REG && (rf.Read_Register1 == '0)) begin
                rdata1_d = '0;
            end else if (BYPASS && wr_en && (rf.Write_Register == rf.Read_Register1)) begin
                rdata1_d = rf.Write_Data;
            end else begin
                rdata1_d = mem_q[rf.Read_Register1];
            end
        end

        if (rf.Read_Enable2) begin
            if (ZERO_REG && (rf.Read_Register2 == '0)) begin
                rdata2_d = '0;
            end else if (BYPASS && wr_en && (rf.Write_Register == rf.Read_Register2)) begin
                rdata2_d = rf.Write_Data;
            end else begin
                rdata2_d = mem_q[rf.Read_Register2];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata1_q  <= '0;
            rdata2_q  <= '0;
            rvalid1_q <= 1'b0;
            rvalid2_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[rf.Write_Register] <= rf.Write_Data;
            end
            rdata1_q  <= rdata1_d;
            rdata2_q  <= rdata2_d;
            rvalid1_q <= rvalid1_d;
            rvalid2_q <= rvalid2_d;
        end
    end

    assign rf.Read_Data1  = rdata1_q;
    assign rf.Read_Data2  = rdata2_q;
    assign rf.Read_Valid1 = rvalid1_q;
    assign rf.Read_Valid2 = rvalid2_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench: three register files (32x32 forwarding, 32x32 non-forwarding, 8x64 forwarding)
// driven by directed vectors; a negedge monitor checks every read result and every idle hold.
module tb_reg_file_param;
    logic clk;
    logic rst;

    reg_file_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifA ();
    reg_file_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifB ();
    reg_file_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) ifC ();

    reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dutA (.Clk(clk), .Reset(rst), .rf(ifA));
    reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b0))
        dutB (.Clk(clk), .Reset(rst), .rf(ifB));
    reg_file_param #(.DATA_WIDTH(64), .ADDR_WIDTH(3), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dutC (.Clk(clk), .Reset(rst), .rf(ifC));

    // The non-forwarding instance sees exactly the same stimulus as the forwarding one.
    assign ifB.Read_Register1 = ifA.Read_Register1;
    assign ifB.Read_Enable1   = ifA.Read_Enable1;
    assign ifB.Read_Register2 = ifA.Read_Register2;
    assign ifB.Read_Enable2   = ifA.Read_Enable2;
    assign ifB.Write_Register = ifA.Write_Register;
    assign ifB.Write_Data     = ifA.Write_Data;
    assign ifB.Reg_Write      = ifA.Reg_Write;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] last_val[6];
    logic [63:0] pat[8];
    int          edge_n   = 0;
    logic        rst_prev = 1'b1;
    int          pass_n   = 0;
    int          total_n  = 0;

    always @(posedge clk) begin
        edge_n   <= edge_n + 1;
        rst_prev <= rst;
    end

    task automatic push(input int p, input logic [63:0] d);
        sb.push_back('{port: p, data: d, due: edge_n + 1});
    endtask

    task automatic mon(input int p, input logic v, input logic [63:0] d);
        int          found;
        exp_t        e;
        logic [63:0] expd;
        found = -1;
        total_n++;
        if (v && !rst_prev) begin
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].port == p) begin
                    found = i;
                    break;
                end
            end
            if (found < 0) begin
                $display("FAIL spurious_valid port%0d: valid=1 data=%h at edge %0d, required no valid", p, d, edge_n);
            end else begin
                e = sb[found];
                sb.delete(found);
                if (d === e.data && edge_n == e.due) pass_n++;
                else $display("FAIL read port%0d: got %h at edge %0d, required %h at edge %0d",
                              p, d, edge_n, e.data, e.due);
            end
            last_val[p] = d;
        end else begin
            expd = rst_prev ? 64'd0 : last_val[p];
            if (!v && d === expd) pass_n++;
            else $display("FAIL hold port%0d: got valid=%b data=%h at edge %0d, required valid=0 data=%h",
                          p, v, d, edge_n, expd);
            last_val[p] = expd;
        end
    endtask

    always @(negedge clk) begin
        mon(0, ifA.Read_Valid1, {32'd0, ifA.Read_Data1});
        mon(1, ifA.Read_Valid2, {32'd0, ifA.Read_Data2});
        mon(2, ifB.Read_Valid1, {32'd0, ifB.Read_Data1});
        mon(3, ifB.Read_Valid2, {32'd0, ifB.Read_Data2});
        mon(4, ifC.Read_Valid1, ifC.Read_Data1);
        mon(5, ifC.Read_Valid2, ifC.Read_Data2);
    end

    task automatic idle_all();
        ifA.Read_Register1 = '0; ifA.Read_Enable1 = 1'b0;
        ifA.Read_Register2 = '0; ifA.Read_Enable2 = 1'b0;
        ifA.Write_Register = '0; ifA.Write_Data   = '0; ifA.Reg_Write = 1'b0;
        ifC.Read_Register1 = '0; ifC.Read_Enable1 = 1'b0;
        ifC.Read_Register2 = '0; ifC.Read_Enable2 = 1'b0;
        ifC.Write_Register = '0; ifC.Write_Data   = '0; ifC.Reg_Write = 1'b0;
    endtask

    // One cycle on the 32-bit pair; eA*/eB* are the expected reads for the forwarding/non-forwarding DUTs.
    task automatic cyA(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re1, input logic [4:0] a1, input logic re2, input logic [4:0] a2,
                       input logic [31:0] eA1, input logic [31:0] eA2,
                       input logic [31:0] eB1, input logic [31:0] eB2);
        idle_all();
        rst = r;
        ifA.Reg_Write = we; ifA.Write_Register = wa; ifA.Write_Data = wd;
        ifA.Read_Enable1 = re1; ifA.Read_Register1 = a1;
        ifA.Read_Enable2 = re2; ifA.Read_Register2 = a2;
        if (!r) begin
            if (re1) begin push(0, {32'd0, eA1}); push(2, {32'd0, eB1}); end
            if (re2) begin push(1, {32'd0, eA2}); push(3, {32'd0, eB2}); end
        end
        @(posedge clk); #2;
    endtask

    task automatic cyC(input logic we, input logic [2:0] wa, input logic [63:0] wd,
                       input logic re1, input logic [2:0] a1, input logic re2, input logic [2:0] a2,
                       input logic [63:0] e1, input logic [63:0] e2);
        idle_all();
        rst = 1'b0;
        ifC.Reg_Write = we; ifC.Write_Register = wa; ifC.Write_Data = wd;
        ifC.Read_Enable1 = re1; ifC.Read_Register1 = a1;
        ifC.Read_Enable2 = re2; ifC.Read_Register2 = a2;
        if (re1) push(4, e1);
        if (re2) push(5, e2);
        @(posedge clk); #2;
    endtask

    initial begin
        for (int i = 0; i < 6; i++) last_val[i] = 64'd0;
        pat[0] = 64'h0000_0000_0000_0000;
        pat[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        pat[2] = 64'hAAAA_AAAA_AAAA_AAAA;
        pat[3] = 64'h5555_5555_5555_5555;
        pat[4] = 64'h8000_0000_0000_0001;
        pat[5] = 64'h0000_0000_0000_0001;
        pat[6] = 64'h0123_4567_89AB_CDEF;
        pat[7] = 64'hFEDC_BA98_7654_3210;
        idle_all();
        rst = 1'b1;

        // Reset with write and read requests active: nothing may take effect.
        cyA(1, 1, 5'd3, 32'hFFFF_FFFF, 1, 5'd3, 1, 5'd4, 0, 0, 0, 0);
        cyA(1, 1, 5'd4, 32'hFFFF_FFFF, 1, 5'd4, 1, 5'd3, 0, 0, 0, 0);

        for (int i = 0; i < 32; i++)
            cyA(0, 0, 5'd0, 32'd0, 1, 5'(i), 1, 5'(31 - i), 0, 0, 0, 0);

        cyA(0, 1, 5'd7, 32'hDEAD_BEEF, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cyA(0, 0, 5'd0, 32'd0, 1, 5'd7, 1, 5'd0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0);

        cyA(0, 1, 5'd0, 32'h1234_5678, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cyA(0, 0, 5'd0, 32'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0);
        cyA(0, 1, 5'd0, 32'h1234_5678, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0);

        cyA(0, 1, 5'd5, 32'h0000_0001, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cyA(0, 1, 5'd5, 32'hA5A5_A5A5, 1, 5'd5, 1, 5'd5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h1, 32'h1);
        cyA(0, 0, 5'd0, 32'd0, 1, 5'd5, 1, 5'd5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        cyA(0, 0, 5'd0, 32'd0, 0, 5'd5, 0, 5'd5, 0, 0, 0, 0);
        cyA(0, 0, 5'd0, 32'd0, 0, 5'd9, 0, 5'd9, 0, 0, 0, 0);

        cyA(0, 1, 5'd31, 32'h8000_0001, 1, 5'd7, 1, 5'd6, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0);
        cyA(0, 1, 5'd1, 32'h5555_5555, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cyA(0, 1, 5'd16, 32'hAAAA_AAAA, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cyA(0, 0, 5'd0, 32'd0, 1, 5'd31, 1, 5'd1, 32'h8000_0001, 32'h5555_5555, 32'h8000_0001, 32'h5555_5555);
        cyA(0, 0, 5'd0, 32'd0, 1, 5'd16, 1, 5'd15, 32'hAAAA_AAAA, 0, 32'hAAAA_AAAA, 0);
        cyA(0, 0, 5'd0, 32'd0, 1, 5'd1, 1, 5'd1, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555);

        // Read due in the reset cycle completes; read requested during reset is discarded.
        cyA(0, 1, 5'd3, 32'hFFFF_FFFF, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cyA(0, 0, 5'd0, 32'd0, 1, 5'd3, 0, 5'd0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0);
        cyA(1, 1, 5'd4, 32'h0000_1234, 1, 5'd3, 0, 5'd0, 0, 0, 0, 0);
        cyA(0, 1, 5'd9, 32'h0000_CAFE, 1, 5'd3, 1, 5'd4, 0, 0, 0, 0);
        cyA(0, 0, 5'd0, 32'd0, 1, 5'd9, 1, 5'd7, 32'h0000_CAFE, 0, 32'h0000_CAFE, 0);

        for (int i = 0; i < 8; i++)
            cyC(0, 3'd0, 64'd0, 1, 3'(i), 1, 3'(7 - i), 64'd0, 64'd0);
        for (int i = 1; i < 8; i++)
            cyC(1, 3'(i), pat[i], 0, 3'd0, 0, 3'd0, 64'd0, 64'd0);
        cyC(1, 3'd0, 64'hDEAD_BEEF_DEAD_BEEF, 0, 3'd0, 0, 3'd0, 64'd0, 64'd0);
        for (int i = 0; i < 8; i++)
            cyC(0, 3'd0, 64'd0, 1, 3'(i), 1, 3'(7 - i), pat[i], pat[7 - i]);
        cyC(1, 3'd5, 64'hA5A5_A5A5_A5A5_A5A5, 1, 3'd5, 1, 3'd5,
            64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5);
        cyC(0, 3'd0, 64'd0, 1, 3'd5, 1, 3'd1, 64'hA5A5_A5A5_A5A5_A5A5, 64'hFFFF_FFFF_FFFF_FFFF);

        cyC(0, 3'd0, 64'd0, 0, 3'd0, 0, 3'd0, 64'd0, 64'd0);
        cyC(0, 3'd0, 64'd0, 0, 3'd0, 0, 3'd0, 64'd0, 64'd0);
        @(negedge clk); #1;

        total_n++;
        if (sb.size() == 0) pass_n++;
        else $display("FAIL scoreboard_drain: %0d reads outstanding, required 0", sb.size());

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
